// File: rtl/sys_csr_trap_pkg.sv
// sys_csr_trap shared definitions: CSR addresses, cause codes,
// mstatus/mip bit positions and the CSR read-modify-write helper.
package sys_csr_trap_pkg;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE = 12'h304;
  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MIP = 12'h344;
  localparam logic [11:0] CSR_MHARTID = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE = 12'hC00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hC80;
  localparam logic [11:0] CSR_TIME = 12'hC01;
  localparam logic [11:0] CSR_TIMEH = 12'hC81;
  localparam logic [11:0] CSR_MINSTRET = 12'hC02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hC82;
  localparam logic [11:0] CSR_MTIMECMP = 12'h7C0;
  localparam logic [11:0] CSR_MTIMECMPH = 12'h7C1;

  localparam logic [31:0] CAUSE_ECALL = 32'd11;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

  localparam int MSTATUS_MIE = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MTIP = 7;
  localparam int MIP_MEIP = 11;

  typedef enum logic [1:0] {
    CSR_NOP,
    CSR_RW,
    CSR_RS,
    CSR_RC
  } csr_op_e;

  function automatic logic [31:0] csr_apply(
    input csr_op_e op,
    input logic [31:0] old,
    input logic [31:0] src
  );
    logic [31:0] r;
    r = old;
    unique case (op)
      CSR_RW: r = src;
      CSR_RS: r = old | src;
      CSR_RC: r = old & ~src;
      default: r = old;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sys_csr_trap_if.sv
// Core-side bus of the CSR/trap unit: system slot, retire count,
// interrupt handshake and front-end redirect.
interface sys_csr_trap_if #(
  parameter int XLEN = 32,
  parameter int RET_W = 2
);
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc;
  logic vld;
  logic [XLEN-1:0] rs0_word;
  logic [RET_W-1:0] retire_num;
  logic ext_irq;
  logic int_req;
  logic int_take;
  logic [XLEN-1:0] int_pc;
  logic jump_vld;
  logic [XLEN-1:0] jump_pc;
  logic [XLEN-1:0] csr_data;

  modport master (
    output instr, pc, vld, rs0_word,
    output retire_num, ext_irq,
    output int_take, int_pc,
    input int_req, jump_vld, jump_pc,
    input csr_data
  );

  modport slave (
    input instr, pc, vld, rs0_word,
    input retire_num, ext_irq,
    input int_take, int_pc,
    output int_req, jump_vld, jump_pc,
    output csr_data
  );
endinterface

// File: rtl/sys_csr_trap_csr_timer.sv
// csr_timer: mtime prescaler, 64-bit mtime, mtimecmp and the
// registered MTIP compare; mtimecmp halves written by the parent.
module csr_timer #(
  parameter int TIME_DIV = 100
) (
  input logic clk,
  input logic rst,
  input logic cmp_we_lo,
  input logic cmp_we_hi,
  input logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic mtip
);
  localparam int PW = $clog2(TIME_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TIME_DIV - 1);

  logic [PW-1:0] pre;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      mtime <= '0;
      mtimecmp <= '1;
      mtip <= 1'b0;
    end else begin
      if (pre == PRE_MAX) begin
        pre <= '0;
        mtime <= mtime + 64'd1;
      end else begin
        pre <= pre + 1'b1;
      end
      if (cmp_we_lo) mtimecmp[31:0] <= wdata;
      if (cmp_we_hi) mtimecmp[63:32] <= wdata;
      mtip <= (mtime >= mtimecmp);
    end
  end
endmodule

// File: rtl/sys_csr_trap.sv
// Machine-mode CSR and trap unit (mstatus/mie/mip/counters/timer).
// Optional vectored interrupt mode under CSR_VECTORED_EN.
module sys_csr_trap
  import sys_csr_trap_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int HART_ID = 0,
  parameter int TIME_DIV = 100,
  parameter int MTVEC_RST = 0,
  parameter int RET_W = 2
) (
  input logic clk,
  input logic rst,
  sys_csr_trap_if.slave bus
);
  function automatic logic [XLEN-1:0] tvec_legal(
    input logic [XLEN-1:0] v
  );
`ifdef CSR_VECTORED_EN
    return {v[XLEN-1:2], 1'b0, (v[1:0] == 2'b01)};
`else
    return {v[XLEN-1:2], 2'b00};
`endif
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rs1;
  logic [11:0] addr;
  logic is_sys, take, act;
  logic csr_en, ecall, xret, fencei, wr;
  csr_op_e op;
  logic [XLEN-1:0] src, wdata, rdata;

  logic st_mie, st_mpie, ie_mtie, ie_meie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause;
  logic [63:0] mcycle, minstret, mtime, mtimecmp;
  logic mtip, sync1, meip;
  logic int_req_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] base;

  assign opc = bus.instr[6:0];
  assign f3 = bus.instr[14:12];
  assign rs1 = bus.instr[19:15];
  assign addr = bus.instr[31:20];

  // an accepted interrupt squashes the slot instruction
  assign take = bus.int_take & int_req_q;
  assign act = bus.vld & ~take;
  assign is_sys = act & (opc == OPC_SYSTEM);
  assign csr_en = is_sys & (f3 != 3'b000);
  assign ecall = is_sys & (bus.instr[31:7] == '0);
  assign xret = is_sys & (f3 == 3'b000)
              & (bus.instr[19:7] == '0)
              & ((addr == 12'h002) | (addr == 12'h102)
               | (addr == 12'h302));
  assign fencei = act & (opc == OPC_MISC_MEM)
                & (f3 == 3'b001);

  always_comb begin
    op = CSR_NOP;
    unique case (f3[1:0])
      2'b01: op = CSR_RW;
      2'b10: op = CSR_RS;
      2'b11: op = CSR_RC;
      default: op = CSR_NOP;
    endcase
  end

  assign src = f3[2] ? XLEN'(rs1) : bus.rs0_word;
  assign wr = csr_en & ((op == CSR_RW)
            | ((op != CSR_NOP) & (rs1 != 5'd0)));
  assign wdata = csr_apply(op, rdata, src);

  always_comb begin
    rdata = '0;
    case (addr)
      CSR_MSTATUS: begin
        rdata[MSTATUS_MIE] = st_mie;
        rdata[MSTATUS_MPIE] = st_mpie;
      end
      CSR_MIE: begin
        rdata[MIP_MTIP] = ie_mtie;
        rdata[MIP_MEIP] = ie_meie;
      end
      CSR_MIP: begin
        rdata[MIP_MTIP] = mtip;
        rdata[MIP_MEIP] = meip;
      end
      CSR_MTVEC: rdata = mtvec;
      CSR_MSCRATCH: rdata = mscratch;
      CSR_MEPC: rdata = mepc;
      CSR_MCAUSE: rdata = mcause;
      CSR_MHARTID: rdata = XLEN'(HART_ID);
      CSR_MCYCLE: rdata = mcycle[31:0];
      CSR_MCYCLEH: rdata = mcycle[63:32];
      CSR_TIME: rdata = mtime[31:0];
      CSR_TIMEH: rdata = mtime[63:32];
      CSR_MINSTRET: rdata = minstret[31:0];
      CSR_MINSTRETH: rdata = minstret[63:32];
      CSR_MTIMECMP: rdata = mtimecmp[31:0];
      CSR_MTIMECMPH: rdata = mtimecmp[63:32];
      default: rdata = '0;
    endcase
  end

  csr_timer #(.TIME_DIV(TIME_DIV)) u_timer (
    .clk(clk),
    .rst(rst),
    .cmp_we_lo(wr & (addr == CSR_MTIMECMP)),
    .cmp_we_hi(wr & (addr == CSR_MTIMECMPH)),
    .wdata(wdata[31:0]),
    .mtime(mtime),
    .mtimecmp(mtimecmp),
    .mtip(mtip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie <= 1'b0;
      st_mpie <= 1'b0;
      ie_mtie <= 1'b0;
      ie_meie <= 1'b0;
      mtvec <= tvec_legal(XLEN'(MTVEC_RST));
      mscratch <= '0;
      mepc <= '0;
      mcause <= '0;
      mcycle <= '0;
      minstret <= '0;
      sync1 <= 1'b0;
      meip <= 1'b0;
      int_req_q <= 1'b0;
      cause_q <= '0;
    end else begin
      mcycle <= mcycle + 64'd1;
      minstret <= minstret + 64'(bus.retire_num);
      {meip, sync1} <= {sync1, bus.ext_irq};
      if (wr) begin
        case (addr)
          CSR_MSTATUS: begin
            st_mie <= wdata[MSTATUS_MIE];
            st_mpie <= wdata[MSTATUS_MPIE];
          end
          CSR_MIE: begin
            ie_mtie <= wdata[MIP_MTIP];
            ie_meie <= wdata[MIP_MEIP];
          end
          CSR_MTVEC: mtvec <= tvec_legal(wdata);
          CSR_MSCRATCH: mscratch <= wdata;
          CSR_MEPC: mepc <= {wdata[XLEN-1:2], 2'b00};
          CSR_MCAUSE: mcause <= wdata;
          default: ;
        endcase
      end
      // trap updates come last so they override a CSR write
      if (take | ecall) begin
        st_mpie <= st_mie;
        st_mie <= 1'b0;
        mcause <= take ? cause_q : XLEN'(CAUSE_ECALL);
        mepc <= take ? {bus.int_pc[XLEN-1:2], 2'b00}
                     : {bus.pc[XLEN-1:2], 2'b00};
      end else if (xret) begin
        st_mie <= st_mpie;
        st_mpie <= 1'b1;
      end
      int_req_q <= ~take & st_mie
                 & ((meip & ie_meie) | (mtip & ie_mtie));
      cause_q <= (meip & ie_meie) ? XLEN'(CAUSE_MEI)
                                  : XLEN'(CAUSE_MTI);
    end
  end

  assign base = {mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    bus.jump_vld = 1'b0;
    bus.jump_pc = '0;
    unique case (1'b1)
      take: begin
        bus.jump_vld = 1'b1;
        bus.jump_pc = base;
`ifdef CSR_VECTORED_EN
        if (mtvec[1:0] == 2'b01)
          bus.jump_pc = base + {cause_q[XLEN-3:0], 2'b00};
`endif
      end
      ecall: begin
        bus.jump_vld = 1'b1;
        bus.jump_pc = base;
      end
      xret: begin
        bus.jump_vld = 1'b1;
        bus.jump_pc = mepc;
      end
      fencei: begin
        bus.jump_vld = 1'b1;
        bus.jump_pc = bus.pc + XLEN'(4);
      end
      default: ;
    endcase
  end

  assign bus.int_req = int_req_q;
  assign bus.csr_data = csr_en ? rdata : '0;
endmodule

// File: tb/tb_sys_csr_trap.sv
// Scoreboard bench for sys_csr_trap (TIME_DIV=4, HART_ID=5);
// vectored expectations follow CSR_VECTORED_EN.
module tb_sys_csr_trap;
  import sys_csr_trap_pkg::*;

`ifdef CSR_VECTORED_EN
  localparam logic [31:0] TV = 32'h101;
  localparam logic [31:0] TJ_T = 32'h11C;
  localparam logic [31:0] TJ_E = 32'h12C;
`else
  localparam logic [31:0] TV = 32'h100;
  localparam logic [31:0] TJ_T = 32'h100;
  localparam logic [31:0] TJ_E = 32'h100;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sys_csr_trap_if #(.XLEN(32), .RET_W(2)) bus ();

  sys_csr_trap #(
    .XLEN(32), .HART_ID(5), .TIME_DIV(4),
    .MTVEC_RST(0), .RET_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string tag;
    logic [31:0] csr;
    logic jv;
    logic [31:0] jpc;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;
  logic [63:0] cyc;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= '0;
    else cyc <= cyc + 64'd1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (!rst && (bus.vld || bus.int_take)) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk({e.tag, ".csr"}, bus.csr_data, e.csr);
        chk({e.tag, ".jv"}, bus.jump_vld, e.jv);
        chk({e.tag, ".jpc"}, bus.jump_pc, e.jpc);
      end
    end
  end

  function automatic logic [31:0] csr_i(
    input logic [2:0] f3,
    input logic [11:0] a,
    input logic [4:0] rs1
  );
    return {a, rs1, f3, 5'd1, OPC_SYSTEM};
  endfunction

  task automatic push(input string tag, input logic [31:0] c,
                      input logic jv, input logic [31:0] jpc);
    exp_t x;
    x.tag = tag;
    x.csr = c;
    x.jv = jv;
    x.jpc = jpc;
    sb.push_back(x);
  endtask

  task automatic issue(input string tag, input logic [31:0] ins,
                       input logic [31:0] p, input logic [31:0] rs,
                       input logic [31:0] ecsr, input logic ejv,
                       input logic [31:0] ejpc);
    @(posedge clk); #1;
    bus.instr = ins;
    bus.pc = p;
    bus.rs0_word = rs;
    bus.vld = 1'b1;
    push(tag, ecsr, ejv, ejpc);
    @(posedge clk); #1;
    bus.vld = 1'b0;
    bus.instr = '0;
  endtask

  task automatic rd(input string tag, input logic [11:0] a,
                    input logic [31:0] exp);
    issue(tag, csr_i(3'b010, a, 5'd0), 0, 0, exp, 0, 0);
  endtask

  task automatic wr(input string tag, input logic [11:0] a,
                    input logic [31:0] v, input logic [31:0] old);
    issue(tag, csr_i(3'b001, a, 5'd1), 0, v, old, 0, 0);
  endtask

  task automatic take(input string tag, input logic [31:0] ipc,
                      input logic [31:0] ejpc);
    @(posedge clk); #1;
    bus.int_take = 1'b1;
    bus.int_pc = ipc;
    push(tag, 0, 1'b1, ejpc);
    @(posedge clk); #1;
    bus.int_take = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int k;
    k = 0;
    while (bus.int_req !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, bus.int_req, 1);
  endtask

  task automatic rd_mcycle();
    @(posedge clk); #1;
    bus.instr = csr_i(3'b010, CSR_MCYCLE, 5'd0);
    bus.vld = 1'b1;
    push("mcycle", cyc[31:0], 0, 0);
    @(posedge clk); #1;
    bus.vld = 1'b0;
    bus.instr = '0;
  endtask

  initial begin
    bus.instr = '0;
    bus.pc = '0;
    bus.vld = 1'b0;
    bus.rs0_word = '0;
    bus.retire_num = '0;
    bus.ext_irq = 1'b0;
    bus.int_take = 1'b0;
    bus.int_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.int_req", bus.int_req, 0);
    chk("rst.jump_vld", bus.jump_vld, 0);
    chk("rst.jump_pc", bus.jump_pc, 0);
    chk("rst.csr_data", bus.csr_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    rd("mtvec_rst", CSR_MTVEC, 32'h0);
    rd("mtimecmp_rst", CSR_MTIMECMPH, 32'hFFFF_FFFF);
    wr("mtvec_w", CSR_MTVEC, 32'h100, 32'h0);
    rd("mtvec_r", CSR_MTVEC, 32'h100);
    issue("ecall", 32'h0000_0073, 32'h80, 0, 0, 1, 32'h100);
    rd("mepc_ecall", CSR_MEPC, 32'h80);
    rd("mcause_ecall", CSR_MCAUSE, 32'd11);
    rd("mstatus_ecall", CSR_MSTATUS, 32'h0);
    issue("fencei", 32'h0000_100F, 32'h40, 0, 0, 1, 32'h44);

    issue("mip_rs_x0", csr_i(3'b010, CSR_MIP, 5'd0),
          0, 32'hFFFF_FFFF, 32'h0, 0, 0);
    wr("hartid_w", CSR_MHARTID, 32'hDEAD, 32'd5);
    rd("hartid_r", CSR_MHARTID, 32'd5);
    wr("unmapped_w", 12'h7FF, 32'h55, 32'h0);
    rd("unmapped_r", 12'h7FF, 32'h0);
    wr("mscratch_w", CSR_MSCRATCH, 32'h1234_5678, 32'h0);
    issue("mscratch_c", csr_i(3'b011, CSR_MSCRATCH, 5'd2),
          0, 32'h0000_FFFF, 32'h1234_5678, 0, 0);
    issue("mscratch_si", csr_i(3'b110, CSR_MSCRATCH, 5'd3),
          0, 0, 32'h1234_0000, 0, 0);
    rd("mscratch_r", CSR_MSCRATCH, 32'h1234_0003);
    wr("mepc_w", CSR_MEPC, 32'h1237, 32'h80);
    rd("mepc_r", CSR_MEPC, 32'h1234);

    rd("minstret0", CSR_MINSTRET, 32'd0);
    @(posedge clk); #1;
    bus.retire_num = 2'd2;
    repeat (10) @(posedge clk);
    #1;
    bus.retire_num = 2'd0;
    rd("minstret20", CSR_MINSTRET, 32'd20);
    rd("minstreth", CSR_MINSTRETH, 32'd0);
    rd_mcycle();
    rd("mcycleh", CSR_MCYCLEH, 32'd0);

    wr("mtvec_w3", CSR_MTVEC, 32'h103, 32'h100);
    rd("mtvec_r3", CSR_MTVEC, 32'h100);
    wr("mtvec_wv", CSR_MTVEC, TV, 32'h100);
    rd("mtvec_rv", CSR_MTVEC, TV);
    wr("cmp_lo", CSR_MTIMECMP, 32'd3, 32'hFFFF_FFFF);
    wr("cmp_hi", CSR_MTIMECMPH, 32'd0, 32'hFFFF_FFFF);
    wr("mie_t", CSR_MIE, 32'h80, 32'h0);
    issue("mie_on", csr_i(3'b110, CSR_MSTATUS, 5'd8),
          0, 0, 32'h0, 0, 0);
    wait_req("timer_req");
    take("timer_take", 32'h200, TJ_T);
    repeat (2) @(posedge clk);
    #1;
    chk("req_clr", bus.int_req, 0);
    rd("mepc_t", CSR_MEPC, 32'h200);
    rd("mcause_t", CSR_MCAUSE, CAUSE_MTI);
    rd("mstatus_t", CSR_MSTATUS, 32'h80);
    rd("mip_t", CSR_MIP, 32'h80);

    wr("mie_te", CSR_MIE, 32'h880, 32'h80);
    bus.ext_irq = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rd("mip_te", CSR_MIP, 32'h880);
    issue("mie_on2", csr_i(3'b110, CSR_MSTATUS, 5'd8),
          0, 0, 32'h80, 0, 0);
    wait_req("ext_req");
    take("ext_take", 32'h300, TJ_E);
    bus.ext_irq = 1'b0;
    rd("mcause_e", CSR_MCAUSE, CAUSE_MEI);
    rd("mstatus_e", CSR_MSTATUS, 32'h80);
    issue("mret", 32'h3020_0073, 32'h50, 0, 0, 1, 32'h300);
    rd("mstatus_mret", CSR_MSTATUS, 32'h88);
    issue("mie_off", csr_i(3'b111, CSR_MSTATUS, 5'd8),
          0, 0, 32'h88, 0, 0);

    issue("mie_on3", csr_i(3'b110, CSR_MSTATUS, 5'd8),
          0, 0, 32'h80, 0, 0);
    wait_req("pre_rst_req");
    #2;
    rst = 1'b1;
    #1;
    chk("arst.int_req", bus.int_req, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd("mstatus_arst", CSR_MSTATUS, 32'h0);
    rd("mtvec_arst", CSR_MTVEC, 32'h0);
    rd("cmp_arst", CSR_MTIMECMP, 32'hFFFF_FFFF);
    rd("mip_arst", CSR_MIP, 32'h0);

    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sys_csr_trap.md
Name: sys_csr_trap

Overview:
- Machine-mode CSR and trap unit; next generation of the system CSR block. Sits beside the scheduler/mprf in the execute stage.
- Adds the following over the previous block:
  - mstatus MIE/MPIE, mie/mip, mscratch and minstret.
  - A prescaled mtime with mtimecmp timer interrupt and a synchronised external interrupt.
  - An interrupt request/take handshake with the core.
- Redirects the front end on ECALL, MRET, FENCE.I and taken interrupts.

Parameters:
- XLEN, 32, data width; all CSRs are XLEN wide except the 64-bit counters.
- HART_ID, 0, value returned by mhartid.
- TIME_DIV, 100, clk cycles per mtime tick (>=2).
- MTVEC_RST, 0, reset value of mtvec.
- RET_W, 2, width of retire_num (instructions retired per cycle, 0..2^RET_W-1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- instr  in  XLEN  instruction at the system slot
- pc  in  XLEN  pc of instr
- vld  in  1  instr valid
- rs0_word  in  XLEN  rs1 operand from mprf
- retire_num  in  RET_W  instructions retired this cycle
- ext_irq  in  1  asynchronous external interrupt level
- int_req  out  1  interrupt pending and enabled
- int_take  in  1  core accepts the interrupt this cycle
- int_pc  in  XLEN  resume pc supplied with int_take
- jump_vld  out  1  redirect valid (combinational)
- jump_pc  out  XLEN  redirect target
- csr_data  out  XLEN  old CSR value for rd writeback (combinational)

Behaviour:
- Reset values:
  - All CSRs 0 except mtvec=MTIVEC_RST... correction: mtvec=MTVEC_RST, and mtimecmp=all-ones.
  - Outputs low/zero after reset.
- CSR instr decode:
  - Condition: vld, opcode 1110011, funct3!=0.
  - Functions: CSRRW/S/C and the immediate forms using zimm=instr[19:15] zero-extended.
  - CSRRS/CSRRC with rs1 field==0 perform no write.
  - Writes land at the next clk edge; csr_data is the pre-write value in the same cycle.
- Address map:
  - mstatus 0x300: bits 3 MIE, 7 MPIE, rest read 0.
  - mie 0x304: bits 7 MTIE, 11 MEIE.
  - mtvec 0x305.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] forced 0.
  - mcause 0x342.
  - mip 0x344: read-only, bit 7 MTIP, bit 11 MEIP.
  - mhartid 0xF14: read-only.
  - mcycle 0xC00/0xC80, time 0xC01/0xC81, minstret 0xC02/0xC82: read-only.
  - mtimecmp 0x7C0 (low) / 0x7C1 (high).
  - Unmapped addresses read 0; writes to them are ignored.
- Counters:
  - mcycle += 1 every cycle.
  - minstret += retire_num every cycle; 64-bit wrap.
  - Prescaler counts 0..TIME_DIV-1; mtime += 1 when the prescaler is at TIME_DIV-1.
  - MTIP = (mtime >= mtimecmp), unsigned 64-bit compare, registered.
- ext_irq passes through a 2-flop synchroniser; MEIP is the synchronised level.
- int_req = mstatus.MIE & ((MEIP&MEIE) | (MTIP&MTIE)). Registered; updates the cycle after any of its inputs change.
- Cause priority: external (0x8000000B) over timer (0x80000007).
- On int_take (sampled only while int_req=1):
  - mepc <= int_pc, mcause <= cause, MPIE <= MIE, MIE <= 0.
  - jump_vld=1, jump_pc = mtvec base (mtvec & ~3).
  - A vld instruction in the same cycle is ignored: no CSR write, no trap. The core squashes it.
- ECALL: mepc <= pc, mcause <= 11, MPIE <= MIE, MIE <= 0; jump to mtvec base.
- MRET (also the URET/SRET encodings): MIE <= MPIE, MPIE <= 1; jump to mepc.
- FENCE.I: jump to pc+4, no state change.
- jump_pc = 0 when jump_vld=0.
- Same-cycle CSR write and trap update to mstatus/mepc/mcause: the trap update wins.
- Reset mid-operation clears the synchroniser, prescaler and any pending int_req immediately.

Optional Feature:
- Macro CSR_VECTORED_EN.
- Defined:
  - mtvec[1:0]==1 selects vectored mode; interrupts jump to base + 4*(cause&0x7FFFFFFF). ECALL still jumps to base.
  - mtvec[1:0] is writable (values 0/1 only; 2/3 written as 0).
- Undefined: mtvec[1:0] reads 0 and all traps jump to base.

Decomposition:
- Shared header: CSR address constants, cause codes, mstatus/mip bit positions.
- One sub-module, csr_timer: prescaler, mtime, mtimecmp registers and MTIP compare. Write enables and data come from the parent.

Test Plan:
- Write mtvec=0x100 via CSRRW, then ECALL at pc 0x80 -> jump_vld=1, jump_pc=0x100; next cycle mepc=0x80, mcause=11, MIE=0.
- Set MIE=1, MTIE=1, mtimecmp=3, TIME_DIV=4 -> int_req rises after mtime reaches 3 (cycle ~13); int_take with int_pc=0x200 -> mepc=0x200, mcause=0x80000007, jump to mtvec.
- ext_irq pulse held 3 cycles with MEIE=MTIE=1 and both pending -> mcause=0x8000000B (external wins); MRET -> jump to mepc, MIE restored to 1.
- CSRRS x0 on mip, then CSRRW to mhartid -> values unchanged, csr_data returns old value.
- retire_num=2 for 10 cycles -> minstret=20; mcycle wrap from 0xFFFFFFFF low to mcycleh += 1.
- CSR_VECTORED_EN: mtvec=0x101, timer interrupt -> jump_pc=0x11C.
